// File: rtl/regfile_pkg.sv
// Shared types and elaboration-time parameter checks for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned data_w,
                                        input int unsigned depth,
                                        input int unsigned n_rd);
        return (data_w >= 1) && is_pow2(depth) && (n_rd >= 1);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write, read and clear-handshake bundle between the decode stage (master) and the register file (slave).
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned N_RD   = 2
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                     we;
    logic [ADDR_W-1:0]        wa;
    logic [DATA_W-1:0]        wd;
    logic                     wready;
    logic [N_RD-1:0]          re;
    logic [N_RD*ADDR_W-1:0]   ra;
    logic [N_RD*DATA_W-1:0]   rd;
    logic [N_RD-1:0]          rvalid;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output we, wa, wd, re, ra, clr_req,
        input  wready, rd, rvalid, clr_busy, clr_done
    );

    modport slave (
        input  we, wa, wd, re, ra, clr_req,
        output wready, rd, rvalid, clr_busy, clr_done
    );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks a pointer over every entry, one per cycle, and
// owns the busy/done handshake and the write-ready decode.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clr_req_i,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              wready_o,
    output logic              clr_busy_o,
    output logic              clr_done_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // NOTE: every output of this block is assigned a default before the case,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        clr_we_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                clr_we_o = 1'b1;
                ptr_d    = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers regardless of evaluation order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The master sees write-ready drop in the same cycle reset is applied.
    assign wready_o   = (state_q == IDLE) && !reset;
    assign clr_addr_o = ptr_q;
    assign clr_busy_o = busy_q;
    assign clr_done_o = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: flop storage with a clear-over-write mux, N registered
// read ports with optional write-first bypass, and an optional hardwired-zero entry 0.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    regfile_mp_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    if (!params_legal(DATA_W, DEPTH, N_RD)) begin : g_param_check
        $error("regfile_mp: DEPTH must be a power of two >= 2; DATA_W and N_RD must be >= 1");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .CLK        (CLK),
        .reset      (reset),
        .clr_req_i  (bus.clr_req),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .wready_o   (bus.wready),
        .clr_busy_o (bus.clr_busy),
        .clr_done_o (bus.clr_done)
    );

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Clear has priority; a dropped entry-0 write is also invisible to the bypass path.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.wa;
        wr_data = bus.wd;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (bus.we && bus.wready) begin
            wr_en = 1'b1;
        end
        if (ZERO_REG && (wr_addr == '0)) begin
            wr_en = 1'b0;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array is reset (and swept) as ordinary flops because reads must
    // return zero right after reset; this precludes mapping it onto a RAM macro.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                mem_q[k] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    logic [ADDR_W-1:0]      ra_port [N_RD];
    logic [N_RD*DATA_W-1:0] rd_q,     rd_d;
    logic [N_RD-1:0]        rvalid_q, rvalid_d;

    always_comb begin
        for (int i = 0; i < int'(N_RD); i++) begin
            ra_port[i] = bus.ra[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rd_d     = rd_q;
        rvalid_d = bus.re;
        for (int i = 0; i < int'(N_RD); i++) begin
            if (bus.re[i]) begin
                rd_d[i*DATA_W +: DATA_W] = mem_q[ra_port[i]];
                if (BYPASS && wr_en && (wr_addr == ra_port[i])) begin
                    rd_d[i*DATA_W +: DATA_W] = wr_data;
                end
                if (ZERO_REG && (ra_port[i] == '0)) begin
                    rd_d[i*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_q     <= '0;
            rvalid_q <= '0;
        end else begin
            rd_q     <= rd_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rd     = rd_q;
    assign bus.rvalid = rvalid_q;

    a_done_not_busy: assert property (@(posedge CLK) disable iff (reset)
        bus.clr_done |-> !bus.clr_busy);

    a_no_user_write_in_sweep: assert property (@(posedge CLK) disable iff (reset)
        clr_we |-> !bus.wready);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (default, no-bypass, zero-reg) driven
// from per-scenario plans; expectations are queued at drive time and popped after each edge.
module tb_regfile_mp;

    typedef struct packed {
        logic       rst;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] re;
        logic [1:0] ra0;
        logic [1:0] ra1;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       busy;
        logic       wready;
        logic       done;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } step_t;

    logic  clk;
    logic  reset;
    int    cur;
    int    n_checks;
    int    n_pass;
    step_t plan_q[$];
    exp_t  sb_q[$];

    logic [15:0] o_rd;
    logic [1:0]  o_valid;
    logic        o_busy, o_wready, o_done;

    regfile_mp_if #(.DATA_W(8), .DEPTH(4), .N_RD(2)) bus (), bus_nb (), bus_z ();

    regfile_mp #(.DATA_W(8), .DEPTH(4), .N_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
        .CLK(clk), .reset(reset), .bus(bus));
    regfile_mp #(.DATA_W(8), .DEPTH(4), .N_RD(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
        .CLK(clk), .reset(reset), .bus(bus_nb));
    regfile_mp #(.DATA_W(8), .DEPTH(4), .N_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
        .CLK(clk), .reset(reset), .bus(bus_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_rd     = bus.rd;
        o_valid  = bus.rvalid;
        o_busy   = bus.clr_busy;
        o_wready = bus.wready;
        o_done   = bus.clr_done;
        if (cur == 1) begin
            o_rd = bus_nb.rd; o_valid = bus_nb.rvalid; o_busy = bus_nb.clr_busy;
            o_wready = bus_nb.wready; o_done = bus_nb.clr_done;
        end else if (cur == 2) begin
            o_rd = bus_z.rd; o_valid = bus_z.rvalid; o_busy = bus_z.clr_busy;
            o_wready = bus_z.wready; o_done = bus_z.clr_done;
        end
    end

    function automatic stim_t S(input int rst, input int we, input int wa, input int wd,
                                input int re, input int ra0, input int ra1, input int clr);
        stim_t s;
        s.rst = 1'(rst); s.we = 1'(we); s.wa = 2'(wa); s.wd = 8'(wd);
        s.re = 2'(re); s.ra0 = 2'(ra0); s.ra1 = 2'(ra1); s.clr = 1'(clr);
        return s;
    endfunction

    function automatic exp_t E(input int valid, input int d0, input int d1,
                               input int busy, input int wready, input int done);
        exp_t e;
        e.valid = 2'(valid); e.d0 = 8'(d0); e.d1 = 8'(d1);
        e.busy = 1'(busy); e.wready = 1'(wready); e.done = 1'(done);
        return e;
    endfunction

    task automatic plan(input stim_t s, input exp_t e);
        plan_q.push_back({s, e});
    endtask

    // Idle stimulus and idle-state expectation used to pad scenarios.
    function automatic stim_t NOP();
        return S(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic exp_t IDLE_E();
        return E(0, 0, 0, 0, 1, 0);
    endfunction

    task automatic drive(input stim_t s);
        stim_t q0, q1, q2;
        q0 = (cur == 0) ? s : '0;
        q1 = (cur == 1) ? s : '0;
        q2 = (cur == 2) ? s : '0;
        reset = s.rst;
        bus.we    = q0.we; bus.wa    = q0.wa; bus.wd    = q0.wd; bus.re    = q0.re;
        bus.ra    = {q0.ra1, q0.ra0}; bus.clr_req    = q0.clr;
        bus_nb.we = q1.we; bus_nb.wa = q1.wa; bus_nb.wd = q1.wd; bus_nb.re = q1.re;
        bus_nb.ra = {q1.ra1, q1.ra0}; bus_nb.clr_req = q1.clr;
        bus_z.we  = q2.we; bus_z.wa  = q2.wa; bus_z.wd  = q2.wd; bus_z.re  = q2.re;
        bus_z.ra  = {q2.ra1, q2.ra0}; bus_z.clr_req  = q2.clr;
    endtask

    function automatic exp_t observe(input exp_t e);
        exp_t g;
        g.valid  = o_valid;
        g.d0     = e.valid[0] ? o_rd[7:0]  : e.d0;
        g.d1     = e.valid[1] ? o_rd[15:8] : e.d1;
        g.busy   = o_busy;
        g.wready = o_wready;
        g.done   = o_done;
        return g;
    endfunction

    task automatic test_reset();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        plan(S(1, 0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(1, 0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(S(0, 0, 0, 0, 3, 0, 1, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 2, 3, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(NOP(), IDLE_E());
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL reset step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    task automatic test_write_read();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        plan(S(0, 1, 3, 8'h03, 0, 0, 0, 0), IDLE_E());
        plan(S(0, 0, 0, 0, 3, 3, 1, 0), E(3, 8'h03, 8'h00, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL write_read step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    task automatic test_bypass();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        plan(S(0, 1, 2, 8'hA5, 1, 2, 0, 0), E(1, 8'hA5, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 2, 2, 0), E(3, 8'hA5, 8'hA5, 0, 1, 0));
        plan(S(0, 0, 0, 0, 2, 0, 3, 0), E(2, 8'h00, 8'h03, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL bypass step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    task automatic test_no_bypass();
        step_t p; exp_t e, g; int n = 0;
        cur = 1;
        plan(S(0, 1, 2, 8'hA5, 3, 2, 2, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 2, 3, 0), E(3, 8'hA5, 8'h00, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL no_bypass step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    task automatic test_zero_reg();
        step_t p; exp_t e, g; int n = 0;
        cur = 2;
        plan(S(0, 1, 0, 8'h7E, 3, 0, 0, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 0, 1, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 1, 1, 8'h7E, 3, 1, 0, 0), E(3, 8'h7E, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 1, 0, 0, 0), E(1, 8'h00, 8'h00, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL zero_reg step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    // Sweep with a write held pending throughout; reads during the sweep see
    // swept entries (or the entry being cleared, via bypass) as zero.
    task automatic test_clear_sweep();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        for (int k = 0; k < 4; k++) plan(S(0, 1, k, 8'h11 * (k + 1), 0, 0, 0, 0), IDLE_E());
        plan(S(0, 1, 1, 8'hFF, 0, 0, 0, 1), E(0, 0, 0, 1, 0, 0));
        plan(S(0, 1, 1, 8'hFF, 3, 0, 2, 0), E(3, 8'h00, 8'h33, 1, 0, 0));
        plan(S(0, 1, 1, 8'hFF, 3, 1, 3, 0), E(3, 8'h00, 8'h44, 1, 0, 0));
        plan(S(0, 1, 1, 8'hFF, 3, 0, 3, 0), E(3, 8'h00, 8'h44, 1, 0, 0));
        plan(S(0, 1, 1, 8'hFF, 3, 3, 1, 0), E(3, 8'h00, 8'h00, 0, 1, 1));
        plan(S(0, 0, 0, 0, 3, 0, 1, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 2, 3, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL clear_sweep step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    // clr_req held through a sweep is ignored until the done cycle, where it restarts.
    task automatic test_back_to_back();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        for (int k = 0; k < 4; k++) plan(S(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 1, 0, 0));
        plan(S(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 0, 1, 1));
        plan(S(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) plan(NOP(), E(0, 0, 0, 1, 0, 0));
        plan(NOP(), E(0, 0, 0, 0, 1, 1));
        plan(NOP(), IDLE_E());
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL back_to_back step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    task automatic test_reset_mid_sweep();
        step_t p; exp_t e, g; int n = 0;
        cur = 0;
        for (int k = 0; k < 4; k++) plan(S(0, 1, k, 8'h5A, 0, 0, 0, 0), IDLE_E());
        plan(S(0, 0, 0, 0, 0, 0, 0, 1), E(0, 0, 0, 1, 0, 0));
        plan(NOP(), E(0, 0, 0, 1, 0, 0));
        plan(S(1, 0, 0, 0, 0, 0, 0, 0), E(0, 0, 0, 0, 0, 0));
        plan(NOP(), IDLE_E());
        plan(NOP(), IDLE_E());
        plan(S(0, 0, 0, 0, 3, 0, 1, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        plan(S(0, 0, 0, 0, 3, 2, 3, 0), E(3, 8'h00, 8'h00, 0, 1, 0));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive(p.s); sb_q.push_back(p.e);
            @(posedge clk); #1;
            e = sb_q.pop_front(); g = observe(e); n_checks++;
            if (g !== e) $display("FAIL reset_mid_sweep step %0d: got %h, want %h (valid,d0,d1,busy,wready,done)", n, g, e);
            else n_pass++;
            n++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cur      = 0;
        drive(S(1, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_write_read();
        test_bypass();
        test_no_bypass();
        test_zero_reg();
        test_clear_sweep();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
